writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 76 +++++++
 rtl/writeback_arbiter.sv | 137 +++++++++++++
 tb/tb_writeback_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and default sizing for the writeback arbiter
package wb_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        reg_idx_t rd;
        word_t    data;
    } wb_entry_t;

    localparam int WB_DEPTH_DEFAULT        = 4;
    localparam int WB_STARVE_LIMIT_DEFAULT = 7;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - mem-result queue with per-entry rd view for hazard matching
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           count,
    output reg_idx_t [DEPTH-1:0]  rd_view,
    output logic [DEPTH-1:0]      valid_view
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    wb_entry_t         store [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DEPTH-1:0]  vld;
    logic              do_push;
    logic              do_pop;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign head       = store[rd_ptr];
    assign valid_view = vld;
    // a full queue refuses a push even if it pops in the same cycle
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;

    // pointers, occupancy and per-slot valid bits; pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                vld[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                vld[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // entry storage; contents are only meaningful where vld is set
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_entry;
        end
    end

    // expose each slot's destination register for hazard comparison
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rd_view[i] = store[i].rd;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - ALU/mem writeback arbiter with starvation guard; optional WB_HAZARD_EN hazard outputs
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = WB_DEPTH_DEFAULT,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT_DEFAULT
) (
    input  logic        WrClk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic [4:0]  Rw,
    output logic        RegWr,
    output logic [31:0] busW,
    input  logic [4:0]  Ra,
    input  logic [4:0]  Rb,
    output logic        hazA,
    output logic        hazB
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          SW      = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0] LIM   = SW'(STARVE_LIMIT);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    wb_entry_t             head;
    logic                  full;
    logic                  empty;
    logic [AW:0]           count;
    reg_idx_t [DEPTH-1:0]  rd_view;
    logic [DEPTH-1:0]      valid_view;
    logic                  push;
    logic                  pop;
    logic                  alu_win;
    logic                  force_head;
    logic                  wr_en;
    reg_idx_t              wr_rd;
    word_t                 wr_data;
    logic [SW-1:0]         starve_cnt;
    logic                  unused_fifo;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (WrClk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry ({mem_rd, mem_data}),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .rd_view    (rd_view),
        .valid_view (valid_view)
    );

    assign unused_fifo = full;
    assign mem_ready   = (count < DEPTH_C);
    // rd==0 results complete the handshake but never occupy a slot
    assign push        = mem_valid && mem_ready && (mem_rd != 5'd0);
    assign force_head  = (starve_cnt == LIM) && !empty;
    assign alu_stall   = alu_valid && force_head;

    // pick this edge's winner: forced head, then ALU, then queue head
    always_comb begin
        pop     = 1'b0;
        alu_win = 1'b0;
        wr_en   = 1'b0;
        wr_rd   = head.rd;
        wr_data = head.data;
        if (force_head) begin
            pop   = 1'b1;
            wr_en = 1'b1;
        end else if (alu_valid) begin
            alu_win = 1'b1;
            wr_rd   = alu_rd;
            wr_data = alu_data;
            wr_en   = (alu_rd != 5'd0);
        end else if (!empty) begin
            pop   = 1'b1;
            wr_en = 1'b1;
        end
    end

    // count consecutive ALU wins over a waiting queue, saturating at the limit
    always_ff @(posedge WrClk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (pop || empty) begin
            starve_cnt <= '0;
        end else if (alu_win && (starve_cnt != LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // registered register-file write port; index/data hold while idle
    always_ff @(posedge WrClk or negedge rst_n) begin
        if (!rst_n) begin
            RegWr <= 1'b0;
            Rw    <= '0;
            busW  <= '0;
        end else begin
            RegWr <= wr_en;
            if (wr_en) begin
                Rw   <= wr_rd;
                busW <= wr_data;
            end
        end
    end

`ifdef WB_HAZARD_EN
    // a read index is hazardous if any queued entry or the in-flight write targets it
    always_comb begin
        hazA = 1'b0;
        hazB = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_view[i] && (rd_view[i] == Ra)) hazA = 1'b1;
            if (valid_view[i] && (rd_view[i] == Rb)) hazB = 1'b1;
        end
        if (RegWr && (Rw == Ra)) hazA = 1'b1;
        if (RegWr && (Rw == Rb)) hazB = 1'b1;
        if (Ra == 5'd0) hazA = 1'b0;
        if (Rb == 5'd0) hazB = 1'b0;
    end
`else
    logic unused_haz;
    assign unused_haz = ^{Ra, Rb, rd_view, valid_view};
    assign hazA       = 1'b0;
    assign hazB       = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - randomized self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIM   = 7;

    logic        WrClk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [4:0]  Rw;
    logic        RegWr;
    logic [31:0] busW;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic        hazA;
    logic        hazB;

    writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .WrClk     (WrClk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .Rw        (Rw),
        .RegWr     (RegWr),
        .busW      (busW),
        .Ra        (Ra),
        .Rb        (Rb),
        .hazA      (hazA),
        .hazB      (hazB)
    );

    always #5 WrClk = ~WrClk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: queue of pending results, starvation count, write port image
    wb_entry_t   q[$];
    int          starve;
    logic        m_regwr;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;
    logic        last_stall;

    task automatic model_reset();
        q.delete();
        starve     = 0;
        m_regwr    = 1'b0;
        m_rw       = '0;
        m_busw     = '0;
        last_stall = 1'b0;
    endtask

    function automatic logic haz_of(input logic [4:0] r);
        logic h;
        h = 1'b0;
`ifdef WB_HAZARD_EN
        if (r != 0) begin
            foreach (q[i]) if (q[i].rd == r) h = 1'b1;
            if (m_regwr && m_rw == r) h = 1'b1;
        end
`endif
        return h;
    endfunction

    // called at a negedge with inputs set: check comb outputs, advance one edge, check write port
    task automatic cycle(input string tag);
        logic      frc, rdy, wr, popped, was_empty;
        wb_entry_t e;
        logic [4:0]  nrw;
        logic [31:0] nbus;
        #1;
        was_empty = (q.size() == 0);
        frc = (starve == LIM) && !was_empty;
        rdy = (q.size() < DEPTH);
        check({tag, ".mem_ready"}, mem_ready, rdy);
        check({tag, ".alu_stall"}, alu_stall, alu_valid && frc);
        check({tag, ".hazA"}, hazA, haz_of(Ra));
        check({tag, ".hazB"}, hazB, haz_of(Rb));
        last_stall = alu_valid && frc;
        wr = 1'b0; popped = 1'b0; nrw = '0; nbus = '0;
        if (frc || (!alu_valid && !was_empty)) begin
            e = q.pop_front();
            wr = 1'b1; popped = 1'b1; nrw = e.rd; nbus = e.data;
        end else if (alu_valid) begin
            if (alu_rd != 0) begin
                wr = 1'b1; nrw = alu_rd; nbus = alu_data;
            end
        end
        if (popped || was_empty) starve = 0;
        else if (alu_valid && starve < LIM) starve++;
        if (mem_valid && rdy && mem_rd != 0) q.push_back({mem_rd, mem_data});
        @(posedge WrClk);
        m_regwr = wr;
        if (wr) begin
            m_rw = nrw; m_busw = nbus;
        end
        @(negedge WrClk);
        check({tag, ".RegWr"}, RegWr, m_regwr);
        check({tag, ".Rw"}, Rw, m_rw);
        check({tag, ".busW"}, busW, m_busw);
    endtask

    // asynchronous reset in mid-cycle; outputs must clear before any edge
    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, ".rst_RegWr"}, RegWr, 1'b0);
        check({tag, ".rst_Rw"}, Rw, 5'd0);
        check({tag, ".rst_busW"}, busW, 32'd0);
        check({tag, ".rst_ready"}, mem_ready, 1'b1);
        check({tag, ".rst_hazA"}, hazA, 1'b0);
        model_reset();
        @(negedge WrClk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        Ra = 0; Rb = 0;
        model_reset();
        @(negedge WrClk);
        check("reset.RegWr", RegWr, 1'b0);
        check("reset.ready", mem_ready, 1'b1);
        check("reset.stall", alu_stall, 1'b0);
        @(negedge WrClk);
        rst_n = 1'b1;

        // single ALU write then idle
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        cycle("alu1");
        check("alu1.exp_RegWr", RegWr, 1'b1);
        check("alu1.exp_busW", busW, 32'h1234);
        alu_valid = 0;
        cycle("alu1_idle");
        check("alu1_idle.exp_RegWr", RegWr, 1'b0);

        // fill queue behind a continuous ALU stream until starvation forces the head
        alu_valid = 1; alu_rd = 9; alu_data = 32'h9999;
        for (int i = 1; i <= 4; i++) begin
            mem_valid = 1; mem_rd = 5'(i); mem_data = 32'h100 + i;
            cycle("starve_fill");
        end
        mem_valid = 0;
        #1 check("starve.full_ready", mem_ready, 1'b0);
        for (int i = 0; i < 6; i++) cycle("starve_run");

        // full queue with pop and a pending offer; drain to verify order
        alu_valid = 0;
        mem_valid = 1; mem_rd = 5'd20; mem_data = 32'hABCD;
        for (int i = 0; i < 8; i++) begin
            cycle("full_pop");
            if (i == 1) mem_valid = 0;
        end

        // three entries queued behind discarded ALU traffic, then reset
        alu_valid = 1; alu_rd = 0;
        for (int i = 1; i <= 3; i++) begin
            mem_valid = 1; mem_rd = 5'(10 + i); mem_data = 32'h300 + i;
            cycle("pre_rst");
        end
        mem_valid = 0;
        mid_reset("rst3");
        for (int i = 0; i < 3; i++) cycle("post_rst");

        // rd==0 offers are accepted and discarded
        alu_valid = 1; alu_rd = 0; mem_valid = 1; mem_rd = 0;
        for (int i = 0; i < 3; i++) cycle("rd0");
        alu_valid = 0; mem_valid = 0;
        cycle("rd0_idle");

`ifdef WB_HAZARD_EN
        mid_reset("haz");
        alu_valid = 1; alu_rd = 0; mem_valid = 1; mem_rd = 7; mem_data = 32'h77;
        Ra = 7; Rb = 0;
        cycle("haz_push");
        mem_valid = 0;
        #1 check("haz.queued_hazA", hazA, 1'b1);
        check("haz.queued_hazB", hazB, 1'b0);
        alu_valid = 0;
        cycle("haz_pop");
        cycle("haz_commit");
        #1 check("haz.after_hazA", hazA, 1'b0);
        @(negedge WrClk);
`endif

        // randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                alu_valid = ($urandom_range(0, 99) < 55);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            mem_valid = ($urandom_range(0, 99) < 50);
            mem_rd    = 5'($urandom_range(0, 7));
            mem_data  = $urandom;
            Ra        = 5'($urandom_range(0, 7));
            Rb        = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 2) mid_reset("rand");
            else cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
